// File: rtl/regfile_bist_pkg.sv
// Shared definitions for the register-file BIST engine: geometry, FSM encoding
// and the address-dependent test pattern.
package regfile_bist_pkg;

   localparam int             RF_DEPTH   = 32;
   localparam int             RF_AW      = 5;
   localparam int             RF_DW      = 32;
   localparam logic [31:0]    RF_SEED    = 32'hA5A5_A5A5;
   localparam logic [31:0]    BYTE_SPLAT = 32'h0101_0101;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR0  = 3'd1,
      ST_RD0  = 3'd2,
      ST_WR1  = 3'd3,
      ST_RD1  = 3'd4,
      ST_DONE = 3'd5
   } bist_state_t;

   // Phase 0 spreads the address into every byte; phase 1 is its complement.
   function automatic logic [31:0] pat(input logic [31:0] x, input logic phase,
                                       input logic [31:0] seed);
      logic [31:0] p;
      p = seed ^ (x * BYTE_SPLAT);
      return phase ? ~p : p;
   endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// Expected-value generation and two-port read-back compare; rd1 wins when
// both ports mismatch in the same cycle.
module regfile_bist_cmp
   import regfile_bist_pkg::*;
#(
   parameter int          DEPTH   = RF_DEPTH,
   parameter int          AW      = RF_AW,
   parameter int          DW      = RF_DW,
   parameter logic [31:0] SEED    = RF_SEED,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic [AW-1:0] a_i,
   input  logic          phase_i,
   input  logic [DW-1:0] rd1_i,
   input  logic [DW-1:0] rd2_i,
   output logic          mismatch_o,
   output logic          port_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o
);

   logic [AW-1:0] addr2;
   logic [DW-1:0] exp1;
   logic [DW-1:0] exp2;

   function automatic logic [DW-1:0] expected(input logic [AW-1:0] x, input logic phase);
      if (R0_ZERO && (x == '0)) return '0;
      return DW'(pat(32'(x), phase, SEED));
   endfunction

   assign addr2 = AW'(DEPTH - 1) - a_i;
   assign exp1  = expected(a_i, phase_i);
   assign exp2  = expected(addr2, phase_i);

   // NOTE: every output gets a default before the branches so no latch is inferred.
   always_comb begin
      mismatch_o = 1'b0;
      port_o     = 1'b0;
      addr_o     = '0;
      data_o     = '0;
      if (rd1_i != exp1) begin
         mismatch_o = 1'b1;
         addr_o     = a_i;
         data_o     = rd1_i;
      end else if (rd2_i != exp2) begin
         mismatch_o = 1'b1;
         port_o     = 1'b1;
         addr_o     = addr2;
         data_o     = rd2_i;
      end
   end

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST: writes two complementary patterns to every register and
// reads each back through both read ports, latching the first mismatch.
module regfile_bist
   import regfile_bist_pkg::*;
#(
   parameter int          DEPTH   = RF_DEPTH,
   parameter int          AW      = RF_AW,
   parameter int          DW      = RF_DW,
   parameter logic [31:0] SEED    = RF_SEED,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW-1:0] fail_addr,
   output logic          fail_port,
   output logic [DW-1:0] fail_data,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd,
   output logic [AW-1:0] rf_ra1,
   output logic [AW-1:0] rf_ra2,
   input  logic [DW-1:0] rf_rd1,
   input  logic [DW-1:0] rf_rd2
);

   localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

   bist_state_t   state_q;
   logic [AW-1:0] a_q;
   logic          busy_q;
   logic          done_q;
   logic          pass_q;
   logic [AW-1:0] fail_addr_q;
   logic          fail_port_q;
   logic [DW-1:0] fail_data_q;

   logic          phase;
   logic          mism;
   logic          mism_port;
   logic [AW-1:0] mism_addr;
   logic [DW-1:0] mism_data;

   assign phase = (state_q == ST_WR1) || (state_q == ST_RD1);

   regfile_bist_cmp #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .DW      (DW),
      .SEED    (SEED),
      .R0_ZERO (R0_ZERO)
   ) u_cmp (
      .a_i        (a_q),
      .phase_i    (phase),
      .rd1_i      (rf_rd1),
      .rd2_i      (rf_rd2),
      .mismatch_o (mism),
      .port_o     (mism_port),
      .addr_o     (mism_addr),
      .data_o     (mism_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_port_q <= 1'b0;
         fail_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q     <= ST_WR0;
                  a_q         <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_addr_q <= '0;
                  fail_port_q <= 1'b0;
                  fail_data_q <= '0;
               end
            end
            ST_WR0, ST_WR1: begin
               if (a_q == A_LAST) begin
                  a_q     <= '0;
                  state_q <= (state_q == ST_WR0) ? ST_RD0 : ST_RD1;
               end else begin
                  a_q <= a_q + 1'b1;
               end
            end
            ST_RD0, ST_RD1: begin
               if (mism) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  fail_addr_q <= mism_addr;
                  fail_port_q <= mism_port;
                  fail_data_q <= mism_data;
               end else if (a_q == A_LAST) begin
                  a_q <= '0;
                  if (state_q == ST_RD0) begin
                     state_q <= ST_WR1;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= 1'b1;
                  end
               end else begin
                  a_q <= a_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Port drive is a pure decode of state and counter, so read data never
   // reaches an output combinationally.
   always_comb begin
      rf_we  = 1'b0;
      rf_wa  = '0;
      rf_wd  = '0;
      rf_ra1 = '0;
      rf_ra2 = '0;
      case (state_q)
         ST_WR0, ST_WR1: begin
            rf_we = 1'b1;
            rf_wa = a_q;
            rf_wd = DW'(pat(32'(a_q), phase, SEED));
         end
         ST_RD0, ST_RD1: begin
            rf_ra1 = a_q;
            rf_ra2 = A_LAST - a_q;
         end
         default: ;
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_addr = fail_addr_q;
   assign fail_port = fail_port_q;
   assign fail_data = fail_data_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench for regfile_bist against a behavioural 32x32 register file
// with selectable fault injection.
module tb_regfile_bist;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy, done, pass, fail_port, rf_we;
   logic [4:0]  fail_addr, rf_wa, rf_ra1, rf_ra2;
   logic [31:0] fail_data, rf_wd, rf_rd1, rf_rd2;

   // 0 good, 1 r9 bit7 stuck-at-0, 2 r0 writable, 3 rd2 inverted at r31
   int          mode;
   logic [31:0] mem [32];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_bist dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_port (fail_port),
      .fail_data (fail_data),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .rf_ra1    (rf_ra1),
      .rf_ra2    (rf_ra2),
      .rf_rd1    (rf_rd1),
      .rf_rd2    (rf_rd2)
   );

   always @(posedge clk)
      if (rf_we && (mode == 2 || rf_wa != 5'd0)) mem[rf_wa] <= rf_wd;

   always_comb begin
      rf_rd1 = (rf_ra1 == 5'd0 && mode != 2) ? 32'h0 : mem[rf_ra1];
      if (mode == 1 && rf_ra1 == 5'd9) rf_rd1[7] = 1'b0;
      rf_rd2 = (rf_ra2 == 5'd0 && mode != 2) ? 32'h0 : mem[rf_ra2];
      if (mode == 1 && rf_ra2 == 5'd9) rf_rd2[7] = 1'b0;
      if (mode == 3 && rf_ra2 == 5'd31) rf_rd2 = ~rf_rd2;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Pulses start, then counts edges until done; optional probes, re-pulse and reset.
   task automatic run(input bit probe, input int repulse_at, input int reset_at,
                      output int cyc);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_cleared", done, 0);
      check("pass_cleared", pass, 0);
      check("fail_addr_cleared", fail_addr, 0);
      if (probe) begin
         check("wr0_we", rf_we, 1);
         check("wr0_wa", rf_wa, 0);
         check("wr0_wd", rf_wd, 32'hA5A5_A5A5);
      end
      cyc = 0;
      while (cyc < 400 && !done) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == repulse_at) start = 1'b1;
         else start = 1'b0;
         if (probe && cyc == 40) begin
            check("rd0_we", rf_we, 0);
            check("rd0_ra1", rf_ra1, 8);
            check("rd0_ra2", rf_ra2, 23);
         end
         if (probe && cyc == 70) begin
            check("wr1_wa", rf_wa, 6);
            check("wr1_wd", rf_wd, 32'h5C5C_5C5C);
         end
         if (cyc == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_ra1", rf_ra1, 0);
            check("rst_ra2", rf_ra2, 0);
            check("rst_we", rf_we, 0);
            check("rst_done", done, 0);
            return;
         end
      end
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_pass", pass, 0);
      check("reset_fail_data", fail_data, 0);
      check("reset_we", rf_we, 0);
      check("reset_wd", rf_wd, 0);
      @(negedge clk) rst_n = 1'b1;

      // 1: clean run
      run(1'b1, -1, -1, cyc);
      check("t1_latency", cyc, 128);
      check("t1_pass", pass, 1);
      check("t1_fail_addr", fail_addr, 0);
      check("t1_fail_port", fail_port, 0);
      check("t1_fail_data", fail_data, 0);

      // 2: r9 bit 7 stuck low
      mode = 1;
      run(1'b0, -1, -1, cyc);
      check("t2_latency", cyc, 42);
      check("t2_pass", pass, 0);
      check("t2_fail_addr", fail_addr, 9);
      check("t2_fail_port", fail_port, 0);
      check("t2_fail_data", fail_data, 32'hACAC_AC2C);

      // 3: r0 holds what was written
      mode = 2;
      run(1'b0, -1, -1, cyc);
      check("t3_latency", cyc, 33);
      check("t3_pass", pass, 0);
      check("t3_fail_addr", fail_addr, 0);
      check("t3_fail_port", fail_port, 0);
      check("t3_fail_data", fail_data, 32'hA5A5_A5A5);

      // 4: rd2 inverted at r31
      mode = 3;
      run(1'b0, -1, -1, cyc);
      check("t4_latency", cyc, 33);
      check("t4_pass", pass, 0);
      check("t4_fail_addr", fail_addr, 31);
      check("t4_fail_port", fail_port, 1);
      check("t4_fail_data", fail_data, 32'h4545_4545);

      // 5: start re-pulsed mid-test is ignored
      mode = 0;
      run(1'b0, 10, -1, cyc);
      check("t5_latency", cyc, 128);
      check("t5_pass", pass, 1);

      // 6: reset during RD0, then a full clean run
      run(1'b0, -1, 40, cyc);
      @(negedge clk) rst_n = 1'b1;
      run(1'b0, -1, -1, cyc);
      check("t6_latency", cyc, 128);
      check("t6_pass", pass, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
